// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampling-free mid-bit sampling feeding a small receive FIFO.
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_rx_fifo #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int fifo_depth     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    input  logic       rx_ack,
    output logic       rx_error,
    output logic       rx_overflow
);
    localparam int DIVISOR = clk_freq / uart_baud_rate;
    localparam int HALF    = DIVISOR / 2;
    localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int AW      = $clog2(fifo_depth);
    localparam logic [BW-1:0] C_BIT_END  = BW'(DIVISOR - 1);
    localparam logic [BW-1:0] C_HALF_END = BW'(HALF - 1);
    localparam logic [AW:0]   C_FULL     = (AW + 1)'(fifo_depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rxd;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          w_bit_end;
    logic          w_half_end;
    logic          w_data_smp;
    logic          w_push;
    logic          w_err;
    logic [7:0]    r_mem [fifo_depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          r_error;
    logic          r_overflow;
`ifdef UART_RX_PARITY_EN
    logic          r_par_err;
    logic          w_par_bad;
`endif

    assign w_rxd      = r_sync2;
    assign w_bit_end  = (r_baud == C_BIT_END);
    assign w_half_end = (r_baud == C_HALF_END);

    // The line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_rxd) w_next = S_START;
            S_START: begin
                if (w_half_end) begin
                    if (w_rxd) w_next = S_IDLE;
                    else       w_next = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_DATA:      if (w_bit_end && r_bit_cnt == 3'd7) w_next = S_PARITY;
            S_PARITY:    if (w_bit_end) w_next = S_STOP;
`else
            S_DATA:      if (w_bit_end && r_bit_cnt == 3'd7) w_next = S_STOP;
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (w_rxd) w_next = S_IDLE;
                    else       w_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: if (w_rxd) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = (r_state == S_PARITY) && w_bit_end && (^{r_shift, w_rxd});
`endif

    // A parity failure already reported suppresses both the push and a second error at stop.
    always_comb begin
        w_data_smp = (r_state == S_DATA) && w_bit_end;
        w_push     = 1'b0;
        w_err      = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (w_par_bad) w_err = 1'b1;
        if (r_state == S_STOP && w_bit_end) begin
            w_push = w_rxd && !r_par_err;
            w_err  = !w_rxd && !r_par_err;
        end
`else
        if (r_state == S_STOP && w_bit_end) begin
            w_push = w_rxd;
            w_err  = !w_rxd;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_next != r_state || w_data_smp || r_state == S_IDLE || r_state == S_WAIT_HIGH)
                r_baud <= '0;
            else
                r_baud <= r_baud + 1'b1;
            if (r_state == S_IDLE)
                r_bit_cnt <= '0;
            else if (w_data_smp)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_data_smp)
                r_shift <= {w_rxd, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_par_err <= 1'b0;
        else if (r_state == S_IDLE) r_par_err <= 1'b0;
        else if (w_par_bad)         r_par_err <= 1'b1;
    end
`endif

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_full = (r_count == C_FULL);
    assign w_pop  = rx_ack && (r_count != '0);
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            r_error    <= w_err;
            r_overflow <= w_push && w_full && !w_pop;
        end
    end

    assign rx_avail    = (r_count != '0);
    assign rx_data     = rx_avail ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_error    = r_error;
    assign rx_overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based receive model checked every cycle, plus directed scenarios.
// Honours UART_RX_PARITY_EN when the design is built with it.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 1152000;
    localparam int DEPTH    = 8;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam int  NBITS     = 10;
    localparam bit  PARITY_ON = 1'b1;
`else
    localparam int  NBITS     = 9;
    localparam bit  PARITY_ON = 1'b0;
`endif
    // Edges from the falling start edge: 2 sync flops, half-bit start check, then whole bits.
    localparam int STOP_K = 2 + HALF + NBITS * DIV;
    localparam int PAR_K  = 2 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_overflow;

    int checks   = 0;
    int failures = 0;
    int errSeen  = 0;
    int ovfSeen  = 0;
    int cyc      = 0;
    int ackMode  = 0;
    int ackRate  = 4;
    bit txBusy   = 1'b0;

    logic [7:0] mq[$];
    logic       expErr  = 1'b0;
    logic       expOvf  = 1'b0;
    bit         pendValid = 1'b0;
    bit         pendPush  = 1'b0;
    bit         pendErr   = 1'b0;
    int         pendPushCyc = 0;
    int         pendErrCyc  = 0;
    logic [7:0] pendByte    = 8'h00;
    bit         doPop;
    bit         doPush;

    logic [7:0] got[16];
    int         nGot;
    int         errBase;
    int         ovfBase;
    logic [7:0] rb;
    bit         rbad;
    bit         rpar;

    uart_rx_fifo #(
        .clk_freq       (CLK_FREQ),
        .uart_baud_rate (BAUD),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .rx_data     (rx_data),
        .rx_avail    (rx_avail),
        .rx_ack      (rx_ack),
        .rx_error    (rx_error),
        .rx_overflow (rx_overflow)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=still_running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame model: the sender knows which edge must push the byte or raise an error.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            expErr    = 1'b0;
            expOvf    = 1'b0;
            pendValid = 1'b0;
        end else begin
            doPop  = rx_ack && (mq.size() > 0);
            doPush = pendValid && pendPush && (cyc == pendPushCyc);
            expErr = pendValid && pendErr && (cyc == pendErrCyc);
            expOvf = doPush && (mq.size() == DEPTH) && !doPop;
            if (doPop) void'(mq.pop_front());
            if (doPush && !expOvf) mq.push_back(pendByte);
            cyc++;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        checkOutput("avail", {31'd0, rx_avail}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) checkOutput("data", {24'd0, rx_data}, {24'd0, mq[0]});
        checkOutput("error", {31'd0, rx_error}, {31'd0, expErr});
        checkOutput("overflow", {31'd0, rx_overflow}, {31'd0, expOvf});
        if (rx_error)    errSeen++;
        if (rx_overflow) ovfSeen++;
    end

    initial forever begin
        @(negedge clk);
        if (ackMode != 0) rx_ack = ($urandom_range(0, ackRate - 1) == 0);
    end

    // Must be entered at a falling clock edge; leaves the line high after the frame.
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit badPar,
                                 input int extraLow, input int gap);
        bit parErr;
        txBusy      = 1'b1;
        parErr      = badPar && PARITY_ON;
        pendByte    = b;
        pendPush    = stopBit && !parErr;
        pendErr     = parErr || !stopBit;
        pendPushCyc = cyc + STOP_K;
        pendErrCyc  = cyc + (parErr ? PAR_K : STOP_K);
        pendValid   = 1'b1;
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^b) ^ badPar;
        repeat (DIV) @(negedge clk);
`endif
        uart_rxd = stopBit;
        repeat (DIV) @(negedge clk);
        if (!stopBit) repeat (extraLow) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (gap) @(negedge clk);
        txBusy = 1'b0;
    endtask

    task automatic drainFifo();
        nGot = 0;
        for (int k = 0; k < 16; k++) got[k] = 8'hEE;
        for (int k = 0; k < 16 && rx_avail; k++) begin
            got[nGot] = rx_data;
            nGot++;
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_avail", {31'd0, rx_avail}, 32'd0);
        checkOutput("reset_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_error", {31'd0, rx_error}, 32'd0);
        checkOutput("reset_overflow", {31'd0, rx_overflow}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] single byte 0xA5");
        txBusy = 1'b1;
        fork applyStimulus(8'hA5, 1'b1, 1'b0, 0, 2); join_none
        repeat (STOP_K) @(posedge clk);
        #2;
        checkOutput("a5_before_push", {31'd0, rx_avail}, 32'd0);
        @(posedge clk);
        #2;
        checkOutput("a5_avail", {31'd0, rx_avail}, 32'd1);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
        while (txBusy) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checkOutput("a5_popped", {31'd0, rx_avail}, 32'd0);

        $display("[TB] nine bytes without ack");
        ovfBase = ovfSeen;
        for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, 1'b0, 0, 2);
        repeat (4) @(negedge clk);
        checkOutput("ovf_pulses", ovfSeen - ovfBase, 32'd1);
        drainFifo();
        checkOutput("ovf_drain_count", nGot, 32'd8);
        for (int i = 0; i < 8; i++) checkOutput("ovf_drain_byte", {24'd0, got[i]}, i);

        $display("[TB] push and pop while full");
        for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, 0, 2);
        ovfBase = ovfSeen;
        txBusy = 1'b1;
        fork applyStimulus(8'h55, 1'b1, 1'b0, 0, 2); join_none
        repeat (STOP_K) @(posedge clk);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        while (txBusy) @(negedge clk);
        checkOutput("full_pp_no_ovf", ovfSeen - ovfBase, 32'd0);
        drainFifo();
        checkOutput("full_pp_count", nGot, 32'd8);
        checkOutput("full_pp_head", {24'd0, got[0]}, 32'h11);
        checkOutput("full_pp_last", {24'd0, got[7]}, 32'h55);

        $display("[TB] framing error then break");
        errBase = errSeen;
        applyStimulus(8'h3C, 1'b0, 1'b0, 20 * DIV, 3 * DIV);
        checkOutput("break_err_pulses", errSeen - errBase, 32'd1);
        checkOutput("break_no_push", {31'd0, rx_avail}, 32'd0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 0, 4);
        checkOutput("break_recover_avail", {31'd0, rx_avail}, 32'd1);
        checkOutput("break_recover_data", {24'd0, rx_data}, 32'h3C);
        drainFifo();

        $display("[TB] short glitch");
        errBase = errSeen;
        uart_rxd = 1'b0;
        repeat (10) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checkOutput("glitch_no_err", errSeen - errBase, 32'd0);
        checkOutput("glitch_no_push", {31'd0, rx_avail}, 32'd0);

        $display("[TB] reset mid-frame");
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * DIV) @(negedge clk);
        checkOutput("abort_no_push", {31'd0, rx_avail}, 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, 0, 4);
        checkOutput("after_reset_avail", {31'd0, rx_avail}, 32'd1);
        checkOutput("after_reset_data", {24'd0, rx_data}, 32'h81);
        drainFifo();
`ifdef UART_RX_PARITY_EN
        errBase = errSeen;
        applyStimulus(8'h81, 1'b1, 1'b1, 0, 4);
        checkOutput("parity_err_pulses", errSeen - errBase, 32'd1);
        checkOutput("parity_no_push", {31'd0, rx_avail}, 32'd0);
`endif

        $display("[TB] random frames");
        ackMode = 1;
        for (int n = 0; n < 44; n++) begin
            ackRate = (n < 22) ? 4 : 1200;
            rb   = 8'($urandom_range(0, 255));
            rbad = ($urandom_range(0, 7) == 0);
            rpar = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                uart_rxd = 1'b0;
                repeat ($urandom_range(1, 15)) @(negedge clk);
                uart_rxd = 1'b1;
                repeat (30) @(negedge clk);
            end
            applyStimulus(rb, !rbad, rpar, $urandom_range(0, 2 * DIV), $urandom_range(2, 20));
        end
        ackMode = 0;
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
